// File: rtl/cmd_proc_gen_if.sv
// Host-side command/response bus of the knight command processor.
interface cmd_proc_gen_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        resp_err;

    modport master (
        output cmd,
        output cmd_rdy,
        input  clr_cmd_rdy,
        input  send_resp,
        input  resp_err
    );

    modport slave (
        input  cmd,
        input  cmd_rdy,
        output clr_cmd_rdy,
        output send_resp,
        output resp_err
    );
endinterface

// File: rtl/cmd_proc_gen.sv
// Knight command processor: decodes host commands, aligns heading, ramps
// forward speed and counts squares crossed on the centre line.
module cmd_proc_gen #(
    parameter bit          FAST_SIM = 1'b1,
    parameter int unsigned HDG_W    = 12,
    parameter int unsigned FRWRD_W  = 10,
    parameter int unsigned SQ_W     = 4,
    parameter int unsigned HDG_TOL  = 'h030
) (
    input  logic                    clk,
    input  logic                    rst,
    cmd_proc_gen_if.slave           host,
    input  logic signed [HDG_W-1:0] heading,
    input  logic                    heading_rdy,
    input  logic                    cal_done,
    input  logic                    lftIR,
    input  logic                    cntrIR,
    input  logic                    rghtIR,
    output logic                    strt_cal,
    output logic                    tour_go,
    output logic                    moving,
    output logic                    fanfare_go,
    output logic [FRWRD_W-1:0]      frwrd,
    output logic signed [HDG_W-1:0] error
);
    localparam int unsigned INC   = FAST_SIM ? 32 : 4;
    localparam int unsigned DEC   = 2 * INC;
    localparam int unsigned NUDGE = FAST_SIM ? 'h1FF : 'h05F;
    localparam int unsigned EXT_W = FRWRD_W + 8;
    localparam int unsigned LOW_W = HDG_W - 8;

    localparam logic [3:0] OP_CAL     = 4'h0;
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;
    localparam logic [3:0] OP_TOUR    = 4'h4;
    localparam logic [3:0] OP_STOP    = 4'hF;

    localparam logic [EXT_W-1:0] FRWRD_MAX = {8'h00, {FRWRD_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, CAL, HEAD, RAMP_UP, RAMP_DN} state_t;

    state_t             state_q, state_d;
    logic [HDG_W-1:0]   desired_q;
    logic [SQ_W-1:0]    sq_cmd_q, sq_count_q;
    logic               ff_q, cir_q;

    logic [3:0]         opcode;
    logic               abort, latch_move, aligned, cir_rise;
    logic [HDG_W-1:0]   hdg_diff, hdg_mag, nudge;
    logic [EXT_W-1:0]   frwrd_ext, frwrd_sum, frwrd_inc, frwrd_dec;
    logic               clr_d, strt_cal_d, tour_go_d, fanfare_go_d, send_resp_d, resp_err_d;

    assign opcode   = host.cmd[15:12];
    assign hdg_diff = $unsigned(heading) - desired_q;
    assign hdg_mag  = hdg_diff[HDG_W-1] ? HDG_W'(-hdg_diff) : hdg_diff;
    assign aligned  = hdg_mag < HDG_W'(HDG_TOL);
    assign cir_rise = cntrIR & ~cir_q;
    assign abort    = ((state_q == HEAD) || (state_q == RAMP_UP)) && host.cmd_rdy && (opcode == OP_STOP);

    // Saturating ramp-up and floored ramp-down, computed in a widened domain
    assign frwrd_ext = EXT_W'(frwrd);
    assign frwrd_sum = frwrd_ext + EXT_W'(INC);
    assign frwrd_inc = (frwrd_sum > FRWRD_MAX) ? FRWRD_MAX : frwrd_sum;
    assign frwrd_dec = (frwrd_ext < EXT_W'(DEC)) ? '0 : frwrd_ext - EXT_W'(DEC);

    always_comb begin
        nudge = '0;
        if (moving && lftIR && !rghtIR)
            nudge = HDG_W'(NUDGE);
        else if (moving && rghtIR && !lftIR)
            nudge = HDG_W'(0) - HDG_W'(NUDGE);
    end

    assign error = $unsigned(heading) - desired_q + nudge;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (host.cmd_rdy) begin
                    if (opcode == OP_CAL)
                        state_d = CAL;
                    else if ((opcode == OP_MOVE) || (opcode == OP_MOVE_FF))
                        state_d = HEAD;
                end
            end
            CAL:     if (cal_done) state_d = IDLE;
            HEAD: begin
                if (abort)        state_d = RAMP_DN;
                else if (aligned) state_d = (sq_cmd_q == '0) ? RAMP_DN : RAMP_UP;
            end
            RAMP_UP: if (abort || (sq_count_q == sq_cmd_q)) state_d = RAMP_DN;
            RAMP_DN: if (frwrd == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_d        = 1'b0;
        strt_cal_d   = 1'b0;
        tour_go_d    = 1'b0;
        fanfare_go_d = 1'b0;
        send_resp_d  = 1'b0;
        resp_err_d   = 1'b0;
        latch_move   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.cmd_rdy) begin
                    clr_d = 1'b1;
                    case (opcode)
                        OP_CAL:              strt_cal_d  = 1'b1;
                        OP_MOVE, OP_MOVE_FF: latch_move  = 1'b1;
                        OP_TOUR:             tour_go_d   = 1'b1;
                        OP_STOP:             send_resp_d = 1'b1;
                        default: begin
                            send_resp_d = 1'b1;
                            resp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            CAL:           if (cal_done) send_resp_d = 1'b1;
            HEAD, RAMP_UP: if (abort) clr_d = 1'b1;
            RAMP_DN: begin
                if (frwrd == '0) begin
                    send_resp_d  = 1'b1;
                    fanfare_go_d = ff_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host.clr_cmd_rdy <= 1'b0;
            host.send_resp   <= 1'b0;
            host.resp_err    <= 1'b0;
            strt_cal         <= 1'b0;
            tour_go          <= 1'b0;
            fanfare_go       <= 1'b0;
            moving           <= 1'b0;
            cir_q            <= 1'b0;
            desired_q        <= '0;
            sq_cmd_q         <= '0;
            sq_count_q       <= '0;
            ff_q             <= 1'b0;
        end else begin
            host.clr_cmd_rdy <= clr_d;
            host.send_resp   <= send_resp_d;
            host.resp_err    <= resp_err_d;
            strt_cal         <= strt_cal_d;
            tour_go          <= tour_go_d;
            fanfare_go       <= fanfare_go_d;
            moving           <= (state_d == HEAD) || (state_d == RAMP_UP) || (state_d == RAMP_DN);
            cir_q            <= cntrIR;
            if (latch_move) begin
                desired_q  <= (host.cmd[11:4] == 8'h00) ? '0 : {host.cmd[11:4], {LOW_W{1'b1}}};
                sq_cmd_q   <= host.cmd[SQ_W-1:0];
                ff_q       <= opcode[0];
                sq_count_q <= '0;
            end else if ((state_q == RAMP_UP) && cir_rise) begin
                sq_count_q <= sq_count_q + SQ_W'(1);
            end
            if (abort) ff_q <= 1'b0;
        end
    end

    // Speed moves only on heading samples while ramping; parked otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            frwrd <= '0;
        end else if (state_q == RAMP_UP) begin
            if (heading_rdy && (frwrd[FRWRD_W-1 -: 2] != 2'b11))
                frwrd <= FRWRD_W'(frwrd_inc);
        end else if (state_q == RAMP_DN) begin
            if (heading_rdy)
                frwrd <= FRWRD_W'(frwrd_dec);
        end else begin
            frwrd <= '0;
        end
    end
endmodule
